pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
// - Parametrised successor to the single-cycle 64-bit ripple adder.
// - WIDTH-bit add/subtract split into STAGES chunk pipeline stages, with the carry registered between stages.
// - Adds a carry-in/subtract mode, ARM NZCV flags and valid/ready flow control with stall.
// - Sits between the ALU issue logic and writeback in the pipelined CPU datapath.
// PARAMETERS
// - WIDTH   64  operand/result width; must be divisible by STAGES.
// - STAGES  4   pipeline depth = latency; 1..WIDTH.
//   - CW = WIDTH/STAGES bits are summed per stage.
// PORTS
// - clk        in   1      single clock; all state updates on the rising edge.
// - reset      in   1      asynchronous, active-low; asserting (0) clears all state immediately.
// - in_valid   in   1      operand beat offered.
// - in_ready   out  1      block can accept a beat this cycle.
// - A          in   WIDTH  operand A.
// - B          in   WIDTH  operand B.
// - sub        in   1      0: A+B+cin; 1: A+~B+1 (cin ignored).
// - cin        in   1      carry-in for the add case (ADC).
// - out_valid  out  1      result beat valid.
// - out_ready  in   1      consumer accepts the result this cycle.
// - out        out  WIDTH  result.
// - flags      out  4      {N,Z,C,V} for the result on out.
// BEHAVIOUR
// - Handshake: a beat transfers when valid && ready on a rising edge.
//   - in_valid/A/B/sub/cin are held by the source until in_ready.
//   - out/flags are held stable while out_valid && !out_ready.
// - Pipeline: stage s holds its valid bit, carry, partial sum bits [s*CW +: CW], and the not-yet-summed upper operand chunks.
//   - Stage s adds chunk s using the carry from stage s-1.
//   - Stage 0 uses cin, or 1 if sub.
//   - B is inverted at entry when sub=1.
// - Stall: adv[S-1] = !v[S-1] | out_ready; adv[s] = !v[s] | adv[s+1].
//   - in_ready = adv[0].
//   - Bubbles collapse; there is no combinational path from in_valid to out_valid.
//   - in_ready depends combinationally on out_ready through the adv chain.
// - Latency: exactly STAGES cycles from input transfer to out_valid when unstalled.
//   - Throughput is 1 beat per cycle.
//   - STAGES=1 is a registered single-cycle adder.
// - Flags, computed from the final stage:
//   - N = out[WIDTH-1].
//   - Z = (out == 0), accumulated per stage as a running zero bit.
//   - C = carry out of bit WIDTH-1. ARM convention: for subtract, C=1 means no borrow.
//   - V = carry into the MSB XOR carry out of the MSB (signed overflow).
// - Reset (reset=0, asynchronous, takes effect mid-operation): all v[s]=0.
//   - out_valid=0, out=0, flags=4'b0000, in_ready=1 once released.
//   - In-flight beats are discarded; the first accepted beat after release reaches the output after STAGES cycles.
// - Simultaneous events:
//   - A full pipeline with out_ready=1 accepts a new input in the same cycle the oldest beat leaves.
//   - A stall freezes every stage.
//   - Result ordering is strictly FIFO.
// - Wrap-around: result is modulo 2^WIDTH; the overflow bit leaves only via C.
// TESTING
// - Reset mid-flight:
//   - Fill the pipe, pull reset low mid-cycle -> out_valid=0 asynchronously, out=0, flags=0.
//   - After release, the next beat emerges STAGES cycles later.
// - Add:
//   - A=64'h0000_0000_FFFF_FFFF, B=1, sub=0, cin=0 -> out=64'h1_0000_0000, flags=4'b0000, exactly 4 cycles after accept.
//   - This checks the carry crossing a chunk boundary.
// - Wrap/overflow:
//   - A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> out=64'h8000_0000_0000_0000, N=1 V=1 C=0 Z=0.
//   - A=all-ones, B=1 -> out=0, Z=1 C=1 V=0.
// - Subtract:
//   - A=5, B=5, sub=1 -> out=0, flags=4'b0110.
//   - A=3, B=5, sub=1 -> out=64'hFFFF_FFFF_FFFF_FFFE, N=1 C=0 V=0.
// - ADC: A=B=64'hFFFF_FFFF_FFFF_FFFF, cin=1 -> out=all-ones, N=1 C=1 Z=0 V=0.
// - Backpressure:
//   - Stream 10 random beats with in_valid always high and out_ready toggling 1,0,0,1...
//   - Required: in-order results matching a reference model, out stable during stalls, 1 beat/cycle when out_ready=1.
//   - Repeat with STAGES=1 and STAGES=8.

Source files
------------

// File: rtl/pipelined_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipelined_addsub                                                 |
// | Brief   : WIDTH-bit add/subtract/ADC split over STAGES carry-pipelined     |
// |           chunks, with NZCV flags and valid/ready flow control.            |
// | Revision: 1.0  initial parametrised release                                |
// +----------------------------------------------------------------------------+
module pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam int c_cw = WIDTH / STAGES;

  logic [STAGES-1:0] w_vld;
  logic [STAGES-1:0] w_adv;

  // A stage may advance when empty or when everything downstream moves.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = !w_vld[STAGES-1] || out_ready;
    for (int s = STAGES - 2; s >= 0; s--) begin
      w_adv[s] = !w_vld[s] || w_adv[s+1];
    end
  end

  assign in_ready = w_adv[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int c_rem = (STAGES - 1 - s) * c_cw;
    localparam int c_low = (s + 1) * c_cw;

    logic             r_v;
    logic             r_c;
    logic             r_z;
    logic [c_low-1:0] r_sum;

    logic             w_pv;
    logic             w_pz;
    logic             w_cin;
    logic [c_cw-1:0]  w_a;
    logic [c_cw-1:0]  w_b;
    logic [c_cw-1:0]  w_chunk;
    logic             w_cout;
    logic [c_low-1:0] w_sum_next;

    if (s == 0) begin : g_entry
      // Subtract is A + ~B + 1, so the inversion happens once, here.
      assign w_pv       = in_valid;
      assign w_pz       = 1'b1;
      assign w_cin      = sub | cin;
      assign w_a        = A[c_cw-1:0];
      assign w_b        = sub ? ~B[c_cw-1:0] : B[c_cw-1:0];
      assign w_sum_next = w_chunk;
    end else begin : g_link
      assign w_pv       = g_stage[s-1].r_v;
      assign w_pz       = g_stage[s-1].r_z;
      assign w_cin      = g_stage[s-1].r_c;
      assign w_a        = g_stage[s-1].g_ops.r_opa[c_cw-1:0];
      assign w_b        = g_stage[s-1].g_ops.r_opb[c_cw-1:0];
      assign w_sum_next = {w_chunk, g_stage[s-1].r_sum};
    end

    assign {w_cout, w_chunk} = {1'b0, w_a} + {1'b0, w_b} + {{c_cw{1'b0}}, w_cin};
    assign w_vld[s] = r_v;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_z   <= 1'b0;
        r_sum <= '0;
      end else if (w_adv[s]) begin
        r_v   <= w_pv;
        r_c   <= w_cout;
        r_z   <= w_pz & (w_chunk == '0);
        r_sum <= w_sum_next;
      end
    end

    // Upper operand chunks still waiting to be summed, kept right-aligned.
    if (c_rem > 0) begin : g_ops
      logic [c_rem-1:0] r_opa;
      logic [c_rem-1:0] r_opb;
      logic [c_rem-1:0] w_opa_next;
      logic [c_rem-1:0] w_opb_next;

      if (s == 0) begin : g_src
        assign w_opa_next = A[WIDTH-1:c_cw];
        assign w_opb_next = sub ? ~B[WIDTH-1:c_cw] : B[WIDTH-1:c_cw];
      end else begin : g_src
        assign w_opa_next = g_stage[s-1].g_ops.r_opa[c_rem+c_cw-1:c_cw];
        assign w_opb_next = g_stage[s-1].g_ops.r_opb[c_rem+c_cw-1:c_cw];
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_opa <= '0;
          r_opb <= '0;
        end else if (w_adv[s]) begin
          r_opa <= w_opa_next;
          r_opb <= w_opb_next;
        end
      end
    end

    // Signed overflow needs the carry into the MSB, visible only in the top chunk.
    if (s == STAGES - 1) begin : g_last
      logic r_ovf;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_ovf <= 1'b0;
        end else if (w_adv[s]) begin
          r_ovf <= (w_a[c_cw-1] ^ w_b[c_cw-1] ^ w_chunk[c_cw-1]) ^ w_cout;
        end
      end
    end
  end

  assign out_valid = w_vld[STAGES-1];
  assign out       = g_stage[STAGES-1].r_sum;
  assign flags     = {out[WIDTH-1], g_stage[STAGES-1].r_z,
                      g_stage[STAGES-1].r_c, g_stage[STAGES-1].g_last.r_ovf};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pipelined_addsub                                              |
// | Brief   : Self-checking bench for pipelined_addsub at STAGES = 4, 1, 8.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pipelined_addsub;

  localparam int W  = 64;
  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          iv   [ND];
  logic          ir   [ND];
  logic [W-1:0]  a    [ND];
  logic [W-1:0]  b    [ND];
  logic          sb   [ND];
  logic          ci   [ND];
  logic          ov   [ND];
  logic          ordy [ND];
  logic [W-1:0]  o    [ND];
  logic [3:0]    f    [ND];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .A(a[0]), .B(b[0]),
    .sub(sb[0]), .cin(ci[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out(o[0]), .flags(f[0]));

  pipelined_addsub #(.WIDTH(W), .STAGES(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .A(a[1]), .B(b[1]),
    .sub(sb[1]), .cin(ci[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out(o[1]), .flags(f[1]));

  pipelined_addsub #(.WIDTH(W), .STAGES(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .A(a[2]), .B(b[2]),
    .sub(sb[2]), .cin(ci[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out(o[2]), .flags(f[2]));

  function automatic int stages_of(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference result {N,Z,C,V,out} from plain integer arithmetic.
  function automatic logic [67:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s, input logic c);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         cy;
    logic         v;
    if (s) begin
      full = {1'b0, x} - {1'b0, y};
      r    = full[W-1:0];
      cy   = (x >= y);
      v    = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      r    = full[W-1:0];
      cy   = full[W];
      v    = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {r[W-1], (r == '0), cy, v, r};
  endfunction

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge with the DUT pipeline empty.
  task automatic directed(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input logic c, input logic [W-1:0] eo,
                          input logic [3:0] ef, input string name);
    int lat;
    string tag;
    tag = $sformatf("dut%0d %s", d, name);
    iv[d] = 1'b1; a[d] = x; b[d] = y; sb[d] = s; ci[d] = c; ordy[d] = 1'b1;
    #1;
    check({tag, " in_ready"}, 68'(ir[d]), 68'(1));
    @(posedge clk);
    @(negedge clk);
    iv[d] = 1'b0;
    lat = 1;
    while (!ov[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 68'(lat), 68'(stages_of(d)));
    check({tag, " out"}, 68'(o[d]), 68'(eo));
    check({tag, " flags"}, 68'(f[d]), 68'(ef));
    @(negedge clk);
  endtask

  task automatic new_beat(output logic [W-1:0] x, output logic [W-1:0] y,
                          output logic s, output logic c);
    x = {$urandom(), $urandom()};
    y = {$urandom(), $urandom()};
    if ($urandom_range(3) == 0) y = x;
    s = 1'($urandom_range(1));
    c = 1'($urandom_range(1));
  endtask

  // Entered at a falling edge; out_ready follows 1,0,0,1,0,0...
  task automatic stream(input int d, input int nbeats);
    logic [67:0]  q[$];
    logic [67:0]  exp;
    logic [67:0]  held_val;
    logic         held;
    logic [W-1:0] x, y;
    logic         s, c;
    int           sent, got, cyc;
    string        tag;
    tag = $sformatf("dut%0d stream", d);
    sent = 0; got = 0; cyc = 0; held = 1'b0; held_val = '0;
    new_beat(x, y, s, c);
    while (got < nbeats && cyc < 300) begin
      ordy[d] = (cyc % 3 == 0);
      iv[d]   = (sent < nbeats);
      a[d] = x; b[d] = y; sb[d] = s; ci[d] = c;
      #1;
      if (held) begin
        check({tag, " stall valid"}, 68'(ov[d]), 68'(1));
        check({tag, " stall hold"}, {f[d], o[d]}, held_val);
      end
      if (ordy[d] && sent < nbeats) check({tag, " throughput"}, 68'(ir[d]), 68'(1));
      if (iv[d] && ir[d]) begin
        q.push_back(ref_model(x, y, s, c));
        sent++;
        new_beat(x, y, s, c);
      end
      if (ov[d] && ordy[d]) begin
        if (q.size() != 0) exp = q.pop_front();
        else exp = 'x;
        check($sformatf("%s result%0d", tag, got), {f[d], o[d]}, exp);
        got++;
        held = 1'b0;
      end else if (ov[d]) begin
        held     = 1'b1;
        held_val = {f[d], o[d]};
      end else begin
        held = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " beats out"}, 68'(got), 68'(nbeats));
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
  endtask

  task automatic all_directed(input int d);
    directed(d, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 4'b0000, "carry chunk");
    directed(d, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'b1001, "signed ovf");
    directed(d, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0, 4'b0110, "wrap zero");
    directed(d, 64'd5, 64'd5, 1'b1, 1'b0, 64'h0, 4'b0110, "sub equal");
    directed(d, 64'd3, 64'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, "sub borrow");
    directed(d, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, 4'b1010, "adc ones");
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < ND; d++) begin
      iv[d] = 1'b0; a[d] = '0; b[d] = '0; sb[d] = 1'b0; ci[d] = 1'b0; ordy[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dut%0d reset out_valid", d), 68'(ov[d]), 68'(0));
      check($sformatf("dut%0d reset out", d), 68'(o[d]), 68'(0));
      check($sformatf("dut%0d reset flags", d), 68'(f[d]), 68'(0));
    end
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dut%0d release in_ready", d), 68'(ir[d]), 68'(1));
    end

    for (int d = 0; d < ND; d++) all_directed(d);
    for (int d = 0; d < ND; d++) stream(d, 10);

    // Fill the 4-stage pipe under backpressure, then reset mid-cycle.
    iv[0] = 1'b1; ordy[0] = 1'b0;
    a[0] = {$urandom(), $urandom()}; b[0] = {$urandom(), 32'h1};
    sb[0] = 1'b0; ci[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("dut0 full out_valid", 68'(ov[0]), 68'(1));
    #3;
    reset = 1'b0;
    #1;
    check("dut0 async out_valid", 68'(ov[0]), 68'(0));
    check("dut0 async out", 68'(o[0]), 68'(0));
    check("dut0 async flags", 68'(f[0]), 68'(0));
    @(negedge clk);
    reset = 1'b1;
    iv[0] = 1'b0; ordy[0] = 1'b1;
    #1;
    check("dut0 post reset in_ready", 68'(ir[0]), 68'(1));
    @(negedge clk);
    directed(0, 64'd3, 64'd5, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, "after reset");
    directed(2, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 4'b0000, "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
